// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_operand_entry
//  Purpose  : Keypad front end for the 8-digit sign-magnitude BCD ALU. Builds
//             operands A and B digit by digit, tracks their signs and the
//             operator, captures the ALU result on '=' and owns the display.
//  Ports    : CLK, RST (async, active-high)
//             KEY_VALID/KEY_CODE/KEY_READY : key event handshake
//             A, B, S_a, S_b, OP           : operands to the ALU
//             ALU_S, ALU_FLAG_S/OV         : combinational ALU result
//             DISP, DISP_SIGN, DISP_OV     : display value and error flag
//             RES_VALID                    : one-cycle new-result pulse
//  Revision : 1.0  initial release
// ============================================================================
module bcd_operand_entry #(
  parameter int DIGITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                KEY_VALID,
  input  logic [3:0]          KEY_CODE,
  output logic                KEY_READY,
  output logic [4*DIGITS-1:0] A,
  output logic [4*DIGITS-1:0] B,
  output logic                S_a,
  output logic                S_b,
  output logic                OP,
  input  logic [4*DIGITS-1:0] ALU_S,
  input  logic                ALU_FLAG_S,
  input  logic                ALU_FLAG_OV,
  output logic [4*DIGITS-1:0] DISP,
  output logic                DISP_SIGN,
  output logic                DISP_OV,
  output logic                RES_VALID
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_EQ   = 4'd12;
  localparam logic [3:0] KEY_SIGN = 4'd13;
  localparam logic [3:0] KEY_CE   = 4'd14;
  localparam logic [3:0] KEY_CA   = 4'd15;

  localparam logic [1:0] ST_ENTER_A = 2'd0;
  localparam logic [1:0] ST_ENTER_B = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_SHOW    = 2'd3;

  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     result;
  logic             result_sign;

  logic key_take, is_digit, is_op, is_sub, digit_ok, clear_all;

  assign key_take = KEY_VALID && (state != ST_COMPUTE);
  assign is_digit = (KEY_CODE <= 4'd9);
  assign is_sub   = (KEY_CODE == KEY_SUB);
  assign is_op    = (KEY_CODE == KEY_ADD) || is_sub;
  // No leading zeros, and a full operand silently ignores further digits.
  assign digit_ok = ((count != '0) || (KEY_CODE != 4'd0)) && (count != CNT_MAX);
  // CA always, and CE while a result is shown, return everything to reset.
  assign clear_all = key_take &&
                     ((KEY_CODE == KEY_CA) || ((state == ST_SHOW) && (KEY_CODE == KEY_CE)));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_ENTER_A;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (clear_all) begin
      next_state = ST_ENTER_A;
    end else begin
      case (state)
        ST_ENTER_A: if (key_take && is_op)                next_state = ST_ENTER_B;
        ST_ENTER_B: if (key_take && (KEY_CODE == KEY_EQ)) next_state = ST_COMPUTE;
        ST_COMPUTE:                                       next_state = ST_SHOW;
        ST_SHOW: begin
          if (key_take && is_digit)                  next_state = ST_ENTER_A;
          else if (key_take && is_op && !DISP_OV)    next_state = ST_ENTER_B;
        end
        default:                                          next_state = ST_ENTER_A;
      endcase
    end
  end

  // Output logic: display follows whichever register the user is looking at.
  always_comb begin
    KEY_READY = (state != ST_COMPUTE);
    DISP      = result;
    DISP_SIGN = result_sign;
    case (state)
      ST_ENTER_A: begin DISP = A; DISP_SIGN = S_a; end
      ST_ENTER_B: begin DISP = B; DISP_SIGN = S_b; end
      default:    ;
    endcase
  end

  // Operand, result and flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A <= '0; B <= '0; S_a <= 1'b0; S_b <= 1'b0; OP <= 1'b0;
      count <= '0; result <= '0; result_sign <= 1'b0;
      DISP_OV <= 1'b0; RES_VALID <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      if (clear_all) begin
        A <= '0; B <= '0; S_a <= 1'b0; S_b <= 1'b0; OP <= 1'b0;
        count <= '0; result <= '0; result_sign <= 1'b0;
        DISP_OV <= 1'b0;
      end else begin
        case (state)
          ST_ENTER_A: if (key_take) begin
            if (is_digit) begin
              if (digit_ok) begin
                A     <= {A[W-5:0], KEY_CODE};
                count <= count + CNT_ONE;
              end
            end else if (is_op) begin
              OP <= is_sub; B <= '0; S_b <= 1'b0; count <= '0;
            end else if (KEY_CODE == KEY_SIGN) begin
              S_a <= ~S_a;
            end else if (KEY_CODE == KEY_CE) begin
              A <= '0; S_a <= 1'b0; count <= '0;
            end
          end
          ST_ENTER_B: if (key_take) begin
            if (is_digit) begin
              if (digit_ok) begin
                B     <= {B[W-5:0], KEY_CODE};
                count <= count + CNT_ONE;
              end
            end else if (is_op) begin
              // Operator can only be corrected before B has any digits.
              if (count == '0) OP <= is_sub;
            end else if (KEY_CODE == KEY_SIGN) begin
              S_b <= ~S_b;
            end else if (KEY_CODE == KEY_CE) begin
              B <= '0; S_b <= 1'b0; count <= '0;
            end
          end
          ST_COMPUTE: begin
            result      <= ALU_S;
            // Suppress negative zero.
            result_sign <= ALU_FLAG_S && (ALU_S != '0);
            DISP_OV     <= ALU_FLAG_OV;
            RES_VALID   <= 1'b1;
          end
          ST_SHOW: if (key_take) begin
            if (is_digit) begin
              A       <= {{(W-4){1'b0}}, KEY_CODE};
              S_a     <= 1'b0;
              count   <= (KEY_CODE != 4'd0) ? CNT_ONE : '0;
              B       <= '0;
              DISP_OV <= 1'b0;
            end else if (is_op && !DISP_OV) begin
              // Chain: the shown result becomes the new A.
              A <= result; S_a <= result_sign; OP <= is_sub;
              B <= '0; S_b <= 1'b0; count <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_operand_entry
//  Purpose  : Self-checking bench for bcd_operand_entry. A behavioural ALU
//             stand-in feeds the DUT; a calculator model holding operands as
//             plain integers predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_operand_entry;

  localparam int DIGITS = 8;
  localparam int W      = 4 * DIGITS;
  localparam longint LIMIT = 100000000;

  localparam int M_A = 0, M_B = 1, M_C = 2, M_S = 3;

  logic         CLK = 1'b0;
  logic         RST;
  logic         KEY_VALID;
  logic [3:0]   KEY_CODE;
  logic         KEY_READY;
  logic [W-1:0] A, B, ALU_S, DISP;
  logic         S_a, S_b, OP, ALU_FLAG_S, ALU_FLAG_OV, DISP_SIGN, DISP_OV, RES_VALID;

  bcd_operand_entry #(.DIGITS(DIGITS)) dut (
    .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .KEY_READY(KEY_READY), .A(A), .B(B), .S_a(S_a), .S_b(S_b), .OP(OP),
    .ALU_S(ALU_S), .ALU_FLAG_S(ALU_FLAG_S), .ALU_FLAG_OV(ALU_FLAG_OV),
    .DISP(DISP), .DISP_SIGN(DISP_SIGN), .DISP_OV(DISP_OV), .RES_VALID(RES_VALID)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  bit force_negzero = 1'b0;

  function automatic longint bcd2int(input logic [W-1:0] x);
    longint v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint signed_calc(input longint a, input bit sa,
                                         input longint b, input bit sb, input bit op);
    longint x = sa ? -a : a;
    longint y = sb ? -b : b;
    return op ? (x - y) : (x + y);
  endfunction

  // Behavioural ALU stand-in
  longint alu_r, alu_mag;
  always_comb begin
    alu_r       = signed_calc(bcd2int(A), S_a, bcd2int(B), S_b, OP);
    alu_mag     = (alu_r < 0) ? -alu_r : alu_r;
    ALU_S       = int2bcd(alu_mag % LIMIT);
    ALU_FLAG_OV = (alu_mag >= LIMIT);
    ALU_FLAG_S  = (alu_r < 0) || force_negzero;
  end

  // Calculator reference model
  int     m_st, m_ca, m_cb;
  longint m_a, m_b, m_res;
  bit     m_sa, m_sb, m_op, m_rs, m_ov, m_rv;

  task automatic m_reset();
    m_st = M_A; m_a = 0; m_b = 0; m_res = 0; m_ca = 0; m_cb = 0;
    m_sa = 0; m_sb = 0; m_op = 0; m_rs = 0; m_ov = 0; m_rv = 0;
  endtask

  task automatic enter(inout longint v, inout int c, input int d);
    if (!(c == 0 && d == 0) && c < DIGITS) begin
      v = v * 10 + d;
      c++;
    end
  endtask

  task automatic m_edge(input bit v, input int k);
    longint r, mag;
    if (m_st == M_C) begin
      r     = signed_calc(m_a, m_sa, m_b, m_sb, m_op);
      mag   = (r < 0) ? -r : r;
      m_res = mag % LIMIT;
      m_ov  = (mag >= LIMIT);
      m_rs  = ((r < 0) || force_negzero) && (m_res != 0);
      m_rv  = 1;
      m_st  = M_S;
      return;
    end
    m_rv = 0;
    if (!v) return;
    if (k == 15) begin m_reset(); return; end
    case (m_st)
      M_A: begin
        if (k <= 9) enter(m_a, m_ca, k);
        else if (k == 10 || k == 11) begin
          m_op = (k == 11); m_b = 0; m_sb = 0; m_cb = 0; m_st = M_B;
        end else if (k == 13) m_sa = !m_sa;
        else if (k == 14) begin m_a = 0; m_sa = 0; m_ca = 0; end
      end
      M_B: begin
        if (k <= 9) enter(m_b, m_cb, k);
        else if (k == 10 || k == 11) begin if (m_cb == 0) m_op = (k == 11); end
        else if (k == 12) m_st = M_C;
        else if (k == 13) m_sb = !m_sb;
        else if (k == 14) begin m_b = 0; m_sb = 0; m_cb = 0; end
      end
      M_S: begin
        if (k <= 9) begin
          m_a = k; m_sa = 0; m_ca = (k != 0) ? 1 : 0; m_b = 0; m_ov = 0; m_st = M_A;
        end else if ((k == 10 || k == 11) && !m_ov) begin
          m_a = m_res; m_sa = m_rs; m_op = (k == 11);
          m_b = 0; m_sb = 0; m_cb = 0; m_st = M_B;
        end else if (k == 14) m_reset();
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e_disp;
    bit           e_sign;
    n_vec++;
    case (m_st)
      M_A:     begin e_disp = int2bcd(m_a);   e_sign = m_sa; end
      M_B:     begin e_disp = int2bcd(m_b);   e_sign = m_sb; end
      default: begin e_disp = int2bcd(m_res); e_sign = m_rs; end
    endcase
    chk("key_ready", W'(KEY_READY), W'(m_st != M_C));
    chk("A",         A,             int2bcd(m_a));
    chk("B",         B,             int2bcd(m_b));
    chk("S_a",       W'(S_a),       W'(m_sa));
    chk("S_b",       W'(S_b),       W'(m_sb));
    chk("OP",        W'(OP),        W'(m_op));
    chk("disp",      DISP,          e_disp);
    chk("disp_sign", W'(DISP_SIGN), W'(e_sign));
    chk("disp_ov",   W'(DISP_OV),   W'(m_ov));
    chk("res_valid", W'(RES_VALID), W'(m_rv));
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic cyc(input bit v, input logic [3:0] k);
    KEY_VALID = v;
    KEY_CODE  = k;
    @(posedge CLK);
    m_edge(v, int'(k));
    @(negedge CLK);
    check_all();
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b1, k);
  endtask

  initial begin
    int r;
    bit v;
    logic [3:0] k;

    RST = 1'b1; KEY_VALID = 1'b0; KEY_CODE = 4'd0;
    m_reset();
    repeat (3) @(negedge CLK);
    check_all();
    RST = 1'b0;
    cyc(1'b0, 4'd0);

    // 12 + 7 = 19
    press(4'd1); press(4'd2); press(4'd10); press(4'd7);
    chk("t1_A", A, 32'h00000012);
    chk("t1_B", B, 32'h00000007);
    chk("t1_OP", W'(OP), 32'h0);
    press(4'd12);
    cyc(1'b0, 4'd0);
    chk("t1_disp", DISP, 32'h00000019);
    chk("t1_rv", W'(RES_VALID), 32'h1);
    cyc(1'b0, 4'd0);
    chk("t1_rv_off", W'(RES_VALID), 32'h0);

    // 5 - 8 = -3, then chain + 4 = 1
    press(4'd15);
    press(4'd5); press(4'd11); press(4'd8); press(4'd12);
    cyc(1'b0, 4'd0);
    chk("t2_disp", DISP, 32'h00000003);
    chk("t2_sign", W'(DISP_SIGN), 32'h1);
    press(4'd10);
    chk("t2_chainA", A, 32'h00000003);
    chk("t2_chainSa", W'(S_a), 32'h1);
    press(4'd4); press(4'd12);
    cyc(1'b0, 4'd0);
    chk("t2_disp2", DISP, 32'h00000001);
    chk("t2_sign2", W'(DISP_SIGN), 32'h0);

    // Overflow: 99999999 + 1
    press(4'd15);
    repeat (8) press(4'd9);
    press(4'd10); press(4'd1); press(4'd12);
    cyc(1'b0, 4'd0);
    chk("t3_ov", W'(DISP_OV), 32'h1);
    press(4'd10);
    chk("t3_ov_hold", W'(DISP_OV), 32'h1);
    press(4'd3);
    chk("t3_newA", A, 32'h00000003);
    chk("t3_ov_clr", W'(DISP_OV), 32'h0);

    // Leading zeros and digit limit
    press(4'd15);
    press(4'd0); press(4'd0); press(4'd1);
    repeat (9) press(4'd9);
    chk("t4_A", A, 32'h19999999);
    press(4'd13); press(4'd13);
    chk("t4_sa", W'(S_a), 32'h0);

    // Negative zero suppression
    press(4'd15);
    press(4'd5); press(4'd11); press(4'd5);
    force_negzero = 1'b1;
    press(4'd12);
    cyc(1'b0, 4'd0);
    force_negzero = 1'b0;
    chk("t5_negzero", W'(DISP_SIGN), 32'h0);

    // KEY_VALID held high across '=' : the key in the COMPUTE cycle is dropped
    press(4'd15);
    press(4'd2); press(4'd10); press(4'd3);
    cyc(1'b1, 4'd12);
    cyc(1'b1, 4'd5);
    cyc(1'b1, 4'd5);
    cyc(1'b1, 4'd5);
    chk("t6_A", A, 32'h00000055);
    cyc(1'b0, 4'd0);

    // Async reset in the middle of COMPUTE
    press(4'd15);
    press(4'd1); press(4'd10); press(4'd2);
    cyc(1'b1, 4'd12);
    KEY_VALID = 1'b0;
    #1 RST = 1'b1;
    m_reset();
    #1 check_all();
    @(negedge CLK);
    check_all();
    RST = 1'b0;
    repeat (3) cyc(1'b0, 4'd0);

    // Randomized key stream
    repeat (800) begin
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 67) k = 4'($urandom_range(10, 11));
      else if (r < 79) k = 4'd12;
      else if (r < 88) k = 4'd13;
      else if (r < 96) k = 4'd14;
      else             k = 4'd15;
      cyc(v, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
